mul_seq_param: RTL and testbench

MUL_SEQ_PARAM -- requirements
Module: mul_seq_param

---
 rtl/mul_seq_param.sv | 114 +++++++++++
 tb/tb_mul_seq_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
//------------------------------------------------------------------------------
// mul_seq_param
//   Sequential radix-2 shift-add multiplier with runtime signed/unsigned mode.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_seq_param #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     a_bi,
    input  logic [WIDTH-1:0]     b_bi,
    input  logic                 signed_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [2*WIDTH-1:0]   y_bo
);

    localparam int                CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WORK = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_valid;
    logic [2*WIDTH-1:0]   r_y;

    logic                 w_sgn;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;

    // The multiply runs on magnitudes; the most-negative value maps to
    // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    assign w_sgn   = (SIGNED_EN == 1'b1) && signed_i;
    assign w_a_neg = w_sgn & a_bi[WIDTH-1];
    assign w_b_neg = w_sgn & b_bi[WIDTH-1];
    assign w_mag_a = w_a_neg ? ({WIDTH{1'b0}} - a_bi) : a_bi;
    assign w_mag_b = w_b_neg ? ({WIDTH{1'b0}} - b_bi) : b_bi;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_y     <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a_sh  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_b_sh  <= w_mag_b;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_WORK;
                    end
                end
                S_WORK: begin
                    // Step k: the shifted copies put mag_b[k] at bit 0 and
                    // mag_a << k in the addend register.
                    if (r_b_sh[0]) begin
                        r_acc <= r_acc + r_a_sh;
                    end
                    r_a_sh <= r_a_sh << 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_y     <= r_neg ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign valid_o = r_valid;
    assign y_bo    = r_y;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_param.sv
//------------------------------------------------------------------------------
// tb_mul_seq_param
//   Directed and random checks of mul_seq_param (WIDTH=8, SIGNED_EN=1).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_seq_param;

    localparam int W = 8;

    logic             clk_i;
    logic             rst_ni;
    logic [W-1:0]     a_bi;
    logic [W-1:0]     b_bi;
    logic             signed_i;
    logic             start_i;
    logic             busy_o;
    logic             valid_o;
    logic [2*W-1:0]   y_bo;

    int checks;
    int failures;

    mul_seq_param #(
        .WIDTH     (W),
        .SIGNED_EN (1'b1)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .a_bi     (a_bi),
        .b_bi     (b_bi),
        .signed_i (signed_i),
        .start_i  (start_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .y_bo     (y_bo)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input bit ok,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference product straight from integer arithmetic on the operand values.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic s);
        longint pa, pb, p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = {1'b1, {(W-1){1'b0}}};
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // One full transaction; operands are scrambled after the accepting edge,
    // and with noise set, start_i is pulsed while the multiplier is busy.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2*W-1:0] exp_y,
                         input bit noise);
        int n;
        a_bi     = a;
        b_bi     = b;
        signed_i = s;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        n = 0;
        while (!valid_o && n < 40) begin
            chk("busy_during_op", busy_o === 1'b1, busy_o, 1'b1);
            a_bi     = W'($urandom);
            b_bi     = W'($urandom);
            signed_i = 1'($urandom_range(0, 1));
            start_i  = noise && (n >= 1) && (n <= W - 1);
            tick();
            n++;
        end
        start_i = 1'b0;
        chk("latency", n == W + 1, n, W + 1);
        chk("result", y_bo === exp_y, y_bo, exp_y);
        chk("busy_after_op", busy_o === 1'b0, busy_o, 1'b0);
        tick();
        chk("valid_single_pulse", valid_o === 1'b0, valid_o, 1'b0);
        chk("result_held", y_bo === exp_y, y_bo, exp_y);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        logic         rs;

        checks   = 0;
        failures = 0;
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        a_bi     = '0;
        b_bi     = '0;
        signed_i = 1'b0;

        tick();
        tick();
        chk("reset_busy", busy_o === 1'b0, busy_o, 1'b0);
        chk("reset_valid", valid_o === 1'b0, valid_o, 1'b0);
        chk("reset_y", y_bo === 16'h0000, y_bo, 16'h0000);

        // First start lands on the first edge with reset released.
        rst_ni = 1'b1;
        do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);

        do_op(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
        do_op(8'h80, 8'h7F, 1'b1, 16'hC080, 1'b0);
        do_op(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
        do_op(8'h00, 8'h80, 1'b1, 16'h0000, 1'b0);
        do_op(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b0);

        // Restart requests during WORK must be ignored.
        do_op(8'd3, 8'd4, 1'b0, 16'd12, 1'b1);

        // Back-to-back with start held high.
        a_bi     = 8'd2;
        b_bi     = 8'd3;
        signed_i = 1'b0;
        start_i  = 1'b1;
        tick();
        a_bi = 8'd7;
        b_bi = 8'd6;
        n = 0;
        while (!valid_o && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_first_latency", n == W + 1, n, W + 1);
        chk("b2b_first_result", y_bo === 16'd6, y_bo, 16'd6);
        n = 0;
        tick();
        n++;
        while (!valid_o && n < 40) begin
            tick();
            n++;
        end
        start_i = 1'b0;
        chk("b2b_pulse_spacing", n == W + 2, n, W + 2);
        chk("b2b_second_result", y_bo === 16'd42, y_bo, 16'd42);
        tick();
        chk("b2b_valid_low", valid_o === 1'b0, valid_o, 1'b0);
        chk("b2b_idle", busy_o === 1'b0, busy_o, 1'b0);

        // Asynchronous reset during WORK aborts the operation.
        a_bi    = 8'd100;
        b_bi    = 8'd100;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        chk("pre_abort_busy", busy_o === 1'b1, busy_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("abort_busy", busy_o === 1'b0, busy_o, 1'b0);
        chk("abort_y", y_bo === 16'h0000, y_bo, 16'h0000);
        chk("abort_valid", valid_o === 1'b0, valid_o, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_no_valid", valid_o === 1'b0, valid_o, 1'b0);
        end
        rst_ni = 1'b1;
        do_op(8'd1, 8'd1, 1'b0, 16'd1, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, ref_mul(ra, rb, rs), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
